// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM.
// Sequences fetch/decode/execute/memory/writeback over one shared memory port.
// Selects and enables are decoded from the current state. The memory-handshake
// enables are additionally gated by i_mem_ready. Reset forces every enable low.
module multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [6:0]           i_op,
  input  logic [2:0]           i_funct3,
  input  logic                 i_zero,
  input  logic                 i_mem_ready,
  output logic                 o_mem_req,
  output logic                 o_adrsrc,
  output logic                 o_memwrite,
  output logic                 o_irwrite,
  output logic                 o_datawrite,
  output logic                 o_pcwrite,
  output logic                 o_regwrite,
  output logic [1:0]           o_alusrca,
  output logic [1:0]           o_alusrcb,
  output logic [1:0]           o_aluop,
  output logic [1:0]           o_resultsrc,
  output logic [1:0]           o_immsrc,
  output logic [2:0]           o_f3,
  output logic                 o_retire,
  output logic                 o_trap,
  output logic [INSTRET_W-1:0] o_instret
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BRANCH, S_TRAP
  } state_t;

  state_t state;

  // State sequencing, sticky trap flag and retired-instruction counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_FETCH;
      o_trap    <= 1'b0;
      o_instret <= '0;
    end else begin
      if (o_retire) o_instret <= o_instret + INSTRET_W'(1);
      case (state)
        S_FETCH:    if (i_mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (i_op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXECR;
            OP_I:              state <= S_EXECI;
            OP_JAL:            state <= S_JAL;
            default: begin
              // only beq/bne are supported among branches
              if (i_op == OP_BR && i_funct3[2:1] == 2'b00) begin
                state <= S_BRANCH;
              end else begin
                state  <= S_TRAP;
                o_trap <= 1'b1;
              end
            end
          endcase
        end
        S_MEMADR:   state <= (i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (i_mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (i_mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of state into datapath controls; reset wins over everything
  always_comb begin
    o_mem_req   = 1'b0;
    o_adrsrc    = 1'b0;
    o_memwrite  = 1'b0;
    o_irwrite   = 1'b0;
    o_datawrite = 1'b0;
    o_pcwrite   = 1'b0;
    o_regwrite  = 1'b0;
    o_alusrca   = 2'b00;
    o_alusrcb   = 2'b00;
    o_aluop     = 2'b00;
    o_resultsrc = 2'b00;
    o_immsrc    = 2'b00;
    o_f3        = 3'b010;
    o_retire    = 1'b0;
    if (!i_rst) begin
      case (i_op)
        OP_STORE: o_immsrc = 2'b01;
        OP_BR:    o_immsrc = 2'b10;
        OP_JAL:   o_immsrc = 2'b11;
        default:  o_immsrc = 2'b00;
      endcase
      case (state)
        S_FETCH: begin
          o_mem_req   = 1'b1;
          o_alusrcb   = 2'b10;
          o_resultsrc = 2'b10;
          o_irwrite   = i_mem_ready;
          o_pcwrite   = i_mem_ready;
        end
        S_DECODE: begin
          // branch/jump target computed ahead into ALUOut
          o_alusrca = 2'b01;
          o_alusrcb = 2'b01;
        end
        S_MEMADR: begin
          o_alusrca = 2'b10;
          o_alusrcb = 2'b01;
        end
        S_MEMREAD: begin
          o_mem_req   = 1'b1;
          o_adrsrc    = 1'b1;
          o_f3        = i_funct3;
          o_datawrite = i_mem_ready;
        end
        S_MEMWB: begin
          o_resultsrc = 2'b01;
          o_regwrite  = 1'b1;
          o_retire    = 1'b1;
        end
        S_MEMWRITE: begin
          o_mem_req  = 1'b1;
          o_adrsrc   = 1'b1;
          o_memwrite = 1'b1;
          o_f3       = i_funct3;
          o_retire   = i_mem_ready;
        end
        S_EXECR: begin
          o_alusrca = 2'b10;
          o_aluop   = 2'b10;
        end
        S_EXECI: begin
          o_alusrca = 2'b10;
          o_alusrcb = 2'b01;
          o_aluop   = 2'b10;
        end
        S_JAL: begin
          o_alusrca = 2'b01;
          o_alusrcb = 2'b10;
          o_pcwrite = 1'b1;
        end
        S_ALUWB: begin
          o_regwrite = 1'b1;
          o_retire   = 1'b1;
        end
        S_BRANCH: begin
          o_alusrca = 2'b10;
          o_aluop   = 2'b01;
          o_pcwrite = (i_funct3 == 3'b000) ? i_zero : ~i_zero;
          o_retire  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the RV32I core. It replaces single-cycle main decoding with a sequenced controller. It steps each instruction through fetch, decode, execute, memory and writeback states over a shared memory port. It drives the datapath's mux selects and write enables, handshakes with the unified memory, and counts retired instructions.

Parameters:
INSTRET_W, 32, width of retired-instruction counter o_instret (wraps modulo 2^INSTRET_W)

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_op  in  7  opcode of latched instruction register
i_funct3  in  3  funct3 of latched instruction register
i_zero  in  1  ALU zero flag
i_mem_ready  in  1  memory completes the current request this cycle
o_mem_req  out  1  memory request valid
o_adrsrc  out  1  memory address: 0=PC, 1=ALUOut
o_memwrite  out  1  memory write enable
o_irwrite  out  1  instruction register (and oldPC) load
o_datawrite  out  1  load-data register enable
o_pcwrite  out  1  PC register write
o_regwrite  out  1  register file write
o_alusrca  out  2  00=PC, 01=oldPC, 10=rs1
o_alusrcb  out  2  00=rs2, 01=imm, 10=constant 4
o_aluop  out  2  00=add, 01=branch compare (sub), 10=funct-decoded
o_resultsrc  out  2  00=ALUOut, 01=load data, 10=ALU result
o_immsrc  out  2  00=I, 01=S, 10=B, 11=J
o_f3  out  3  memory access size; i_funct3 in MEMREAD/MEMWRITE, else 3'b010
o_retire  out  1  one-cycle pulse when an instruction completes
o_trap  out  1  illegal instruction detected; held until reset
o_instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Outputs are Moore decode of state. Exceptions: o_irwrite, o_pcwrite (FETCH), o_datawrite, o_memwrite-completion and o_retire (MEMWRITE) are additionally gated by i_mem_ready.
- While i_rst=1: next state FETCH, o_instret<=0, o_trap<=0. All enables and o_mem_req, o_retire forced 0. Selects and o_aluop/o_immsrc=0. o_f3=3'b010.
- States and outputs (unlisted outputs are 0; o_immsrc is decoded from i_op in all states: lw/addi=00, sw=01, branch=10, jal=11):
- FETCH: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. On i_mem_ready: irwrite=1, pcwrite=1, go to DECODE. Otherwise hold FETCH with no writes.
- DECODE: alusrca=01, alusrcb=01, aluop=00 (branch/jump target into ALUOut). Next by i_op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 with funct3 000/001 -> BRANCH; anything else -> TRAP.
- MEMADR: alusrca=10, alusrcb=01, aluop=00. Next: load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: mem_req=1, adrsrc=1, f3=i_funct3. On ready: datawrite=1, go to MEMWB; else stay.
- MEMWB: resultsrc=01, regwrite=1, retire=1. Go to FETCH.
- MEMWRITE: mem_req=1, adrsrc=1, memwrite=1, f3=i_funct3. Hold while !ready. On ready: retire=1, go to FETCH.
- EXECR: alusrca=10, alusrcb=00, aluop=10. Go to ALUWB.
- EXECI: alusrca=10, alusrcb=01, aluop=10. Go to ALUWB.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcwrite=1. Go to ALUWB.
- ALUWB: resultsrc=00, regwrite=1, retire=1. Go to FETCH.
- BRANCH: alusrca=10, alusrcb=00, aluop=01, resultsrc=00. pcwrite = (funct3==000) ? i_zero : ~i_zero. retire=1. Go to FETCH.
- TRAP: o_trap=1, all enables 0, mem_req=0. Stays in TRAP until i_rst.
- Zero-wait latency in cycles: branch 3, sw 4, R/I/jal 4, lw 5. Each cycle with i_mem_ready=0 in a memory state adds exactly one cycle.
- o_instret increments by 1 on the o_retire edge and wraps at all-ones to 0.
- Reset mid-instruction (including mid-wait): the outstanding request is abandoned. No write enable is asserted in the reset cycle. Fetch restarts on the next cycle.

Test Plan:
- Reset, then add x3,x1,x2 with ready always 1 -> states FETCH,DECODE,EXECR,ALUWB; regwrite high only in cycle 4; o_instret=1.
- lw with ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles; datawrite one pulse coincident with ready; o_f3=3'b010; total 7 cycles.
- beq with i_zero=1 -> pcwrite high in BRANCH. bne (funct3 001) with i_zero=1 -> pcwrite low. Both retire after 3 cycles.
- sb (funct3 000) -> o_f3=000 and memwrite in MEMWRITE, o_immsrc=01, no regwrite; jal -> pcwrite in JAL, regwrite with resultsrc=00 in ALUWB.
- Opcode 7'b1110011 -> TRAP after DECODE; o_trap stays 1 for 10+ cycles, no mem_req; then i_rst -> o_trap=0, FETCH.
- Preload 2^INSTRET_W-1 retires (INSTRET_W=4: 15 addi) -> next retire gives o_instret=0; i_rst asserted during FETCH wait -> no irwrite/pcwrite that cycle.
